// File: rtl/lcd_sequencer.sv
// lcd_sequencer
//   Drives an LCD init/refresh engine. After reset it waits POWERUP_CYCLES,
//   launches one init sequence, then issues a refresh every REFRESH_CYCLES
//   idle cycles or sooner when the host asks for one with upd_req.
//
// Parameters
//   POWERUP_CYCLES  cycles waited in PWRUP before the init sequence
//   REFRESH_CYCLES  idle cycles between autonomous refreshes
//   INIT_CNT        lcd_cnt value for the init sequence
//   REFRESH_CNT     lcd_cnt value for a refresh sequence
//   TIMEOUT_CYCLES  watchdog limit in the WAIT states (LCD_SEQ_TIMEOUT_EN only)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   lcd_finish  pulse from engine: sequence complete (ignored outside WAIT)
//   upd_req     pulse from host: request a refresh
//   lcd_enable  one-cycle start pulse to the engine
//   mode        1 = init sequence, 0 = refresh sequence
//   lcd_cnt     item count of the current sequence
//   init_done   sticky, set when init completes
//   busy        high in INIT_START/INIT_WAIT/REF_START/REF_WAIT
//   upd_ack     pulse in the REF_START that serves a pending upd_req
//   err         sticky watchdog error
//
// Configuration
//   LCD_SEQ_TIMEOUT_EN  when defined, a watchdog bounds the WAIT states;
//                       otherwise err is tied low and WAIT states never expire.
//
// Handshake: lcd_enable is a single-cycle start strobe; the engine answers
// with a single-cycle lcd_finish, and only a finish seen while this block is
// in a WAIT state is taken as the completion of the outstanding sequence.
//
// All outputs are flops loaded from the next-state value, so they change on
// the same edge as the state register.

module lcd_sequencer #(
    parameter int         POWERUP_CYCLES = 750000,
    parameter int         REFRESH_CYCLES = 2500000,
    parameter logic [1:0] INIT_CNT       = 2'd3,
    parameter logic [1:0] REFRESH_CNT    = 2'd3,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_finish,
    input  logic       upd_req,
    output logic       lcd_enable,
    output logic       mode,
    output logic [1:0] lcd_cnt,
    output logic       init_done,
    output logic       busy,
    output logic       upd_ack,
    output logic       err
);

    localparam logic [2:0] PWRUP      = 3'd0;
    localparam logic [2:0] INIT_START = 3'd1;
    localparam logic [2:0] INIT_WAIT  = 3'd2;
    localparam logic [2:0] IDLE       = 3'd3;
    localparam logic [2:0] REF_START  = 3'd4;
    localparam logic [2:0] REF_WAIT   = 3'd5;

    localparam int PW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic          pend;
    logic          pend_next;
    logic [PW-1:0] pwr_cnt;
    logic [RW-1:0] ref_cnt;

`ifdef LCD_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] wd_cnt;
    logic          wd_hit;
    assign wd_hit = ((state == INIT_WAIT) || (state == REF_WAIT)) &&
                    !lcd_finish && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_next = state;
        case (state)
            PWRUP:      if (pwr_cnt == PW'(POWERUP_CYCLES - 1)) state_next = INIT_START;
            INIT_START: state_next = INIT_WAIT;
            INIT_WAIT: begin
                if (lcd_finish) state_next = IDLE;
`ifdef LCD_SEQ_TIMEOUT_EN
                else if (wd_hit) state_next = INIT_START;
`endif
            end
            IDLE:       if (pend || (ref_cnt == RW'(REFRESH_CYCLES - 1))) state_next = REF_START;
            REF_START:  state_next = REF_WAIT;
            REF_WAIT: begin
                if (lcd_finish) state_next = IDLE;
`ifdef LCD_SEQ_TIMEOUT_EN
                else if (wd_hit) state_next = IDLE;
`endif
            end
            default:    state_next = PWRUP;
        endcase
    end

    // REF_START consumes the pending request, but a request arriving in that
    // same cycle must survive for the following refresh.
    always_comb begin
        pend_next = pend | upd_req;
        if (state == REF_START) pend_next = upd_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PWRUP;
            pend       <= 1'b0;
            pwr_cnt    <= '0;
            ref_cnt    <= '0;
            lcd_enable <= 1'b0;
            mode       <= 1'b1;
            lcd_cnt    <= 2'd0;
            init_done  <= 1'b0;
            busy       <= 1'b0;
            upd_ack    <= 1'b0;
        end else begin
            state <= state_next;
            pend  <= pend_next;

            // Counters only run while their state persists, so they are zero
            // again whenever the state is next entered.
            pwr_cnt <= ((state == PWRUP) && (state_next == PWRUP)) ? pwr_cnt + 1'b1 : '0;
            ref_cnt <= ((state == IDLE) && (state_next == IDLE)) ? ref_cnt + 1'b1 : '0;

            lcd_enable <= (state_next == INIT_START) || (state_next == REF_START);
            busy       <= (state_next != PWRUP) && (state_next != IDLE);
            upd_ack    <= (state_next == REF_START) && pend_next;

            case (state_next)
                PWRUP: begin
                    mode    <= 1'b1;
                    lcd_cnt <= 2'd0;
                end
                INIT_START, INIT_WAIT: begin
                    mode    <= 1'b1;
                    lcd_cnt <= INIT_CNT;
                end
                REF_START, REF_WAIT: begin
                    mode    <= 1'b0;
                    lcd_cnt <= REFRESH_CNT;
                end
                default: ;  // IDLE keeps the last sequence's mode/count
            endcase

            if ((state == INIT_WAIT) && lcd_finish) init_done <= 1'b1;
        end
    end

`ifdef LCD_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            wd_cnt <= (((state == INIT_WAIT) || (state == REF_WAIT)) && (state_next == state))
                      ? wd_cnt + 1'b1 : '0;
            if (wd_hit) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with POWERUP_CYCLES=10, REFRESH_CYCLES=20,
// TIMEOUT_CYCLES=8. Inputs change 1 ns after a rising edge and outputs are
// read at that same point, so every read sees the values loaded by the edge.

module tb_lcd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_finish = 1'b0;
    logic       upd_req = 1'b0;
    logic       lcd_enable;
    logic       mode;
    logic [1:0] lcd_cnt;
    logic       init_done;
    logic       busy;
    logic       upd_ack;
    logic       err;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int ack_cnt   = 0;

    lcd_sequencer #(
        .POWERUP_CYCLES(10),
        .REFRESH_CYCLES(20),
        .INIT_CNT(2'd3),
        .REFRESH_CNT(2'd3),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lcd_finish(lcd_finish),
        .upd_req(upd_req),
        .lcd_enable(lcd_enable),
        .mode(mode),
        .lcd_cnt(lcd_cnt),
        .init_done(init_done),
        .busy(busy),
        .upd_ack(upd_ack),
        .err(err)
    );

    // clock / reset
    always #5 clk = ~clk;

    // running count of upd_ack pulses, sampled mid-cycle
    always @(negedge clk) if (!rst && upd_ack) ack_cnt <= ack_cnt + 1;

    // checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else
            pass_cnt++;
    endtask

    // drivers
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance until lcd_enable is seen; n is the number of edges taken.
    task automatic wait_enable(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!lcd_enable && n < 200);
    endtask

    // k more cycles in the WAIT state, then a one-cycle lcd_finish.
    task automatic finish_after(input int k);
        repeat (k) tick();
        lcd_finish = 1'b1;
        tick();
        lcd_finish = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enable"}, lcd_enable, 0);
        check({tag, "_mode"}, mode, 1);
        check({tag, "_cnt"}, lcd_cnt, 0);
        check({tag, "_init_done"}, init_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ack"}, upd_ack, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int n;
        int ack_snap;
        int en;

        // reset state
        repeat (3) tick();
        check_reset_outputs("rst");

        // power-up with an upd_req during PWRUP: 10 PWRUP cycles, then INIT_START
        rst = 1'b0;
        repeat (2) tick();
        upd_req = 1'b1;
        tick();
        upd_req = 1'b0;
        check("pwrup_no_enable", lcd_enable, 0);
        wait_enable(n);
        check("init_start_delay", n + 3, 10);
        check("init_mode", mode, 1);
        check("init_cnt", lcd_cnt, 3);
        check("init_busy", busy, 1);
        check("init_err", err, 0);

        // INIT_WAIT then lcd_finish -> IDLE with init_done
        tick();
        check("init_wait_enable", lcd_enable, 0);
        check("init_wait_busy", busy, 1);
        check("init_wait_mode", mode, 1);
        repeat (3) tick();
        check("init_done_early", init_done, 0);
        finish_after(0);
        check("init_done", init_done, 1);
        check("idle_busy", busy, 0);

        // pending request from PWRUP is served by the first refresh
        wait_enable(n);
        check("pend_ref_delay", n, 1);
        check("pend_ref_ack", upd_ack, 1);
        check("pend_ref_mode", mode, 0);
        check("pend_ref_cnt", lcd_cnt, 3);
        check("pend_ref_busy", busy, 1);
        tick();
        check("ack_one_cycle", upd_ack, 0);
        finish_after(1);

        // autonomous refresh after 20 idle cycles; upd_req coincident with REF_START
        wait_enable(n);
        check("auto_ref_delay", n, 20);
        check("auto_ref_ack", upd_ack, 0);
        check("auto_ref_mode", mode, 0);
        upd_req = 1'b1;
        tick();
        upd_req = 1'b0;
        finish_after(2);
        wait_enable(n);
        check("coinc_ref_delay", n, 1);
        check("coinc_ref_ack", upd_ack, 1);

        // three requests during REF_WAIT collapse into a single ack
        tick();
        ack_snap = ack_cnt;
        for (int i = 0; i < 3; i++) begin
            upd_req = 1'b1;
            tick();
            upd_req = 1'b0;
            tick();
        end
        finish_after(0);
        wait_enable(n);
        check("multi_ref_delay", n, 1);
        check("multi_ref_ack", upd_ack, 1);
        finish_after(1);
        wait_enable(n);
        check("after_multi_delay", n, 20);
        check("after_multi_ack", upd_ack, 0);
        check("multi_ack_count", ack_cnt - ack_snap, 1);

        // reset in REF_WAIT with a request pending: asynchronous abort
        tick();
        upd_req = 1'b1;
        tick();
        upd_req = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        #2 rst = 1'b0;
        wait_enable(n);
        check("re_init_delay", n, 10);
        check("re_init_mode", mode, 1);
        check("re_init_done", init_done, 0);

        // lcd_finish withheld in INIT_WAIT
`ifdef LCD_SEQ_TIMEOUT_EN
        wait_enable(n);
        check("wd_restart_delay", n, 9);
        check("wd_err", err, 1);
        check("wd_restart_mode", mode, 1);
        check("wd_init_done", init_done, 0);
        finish_after(1);
`else
        en = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (lcd_enable) en++;
        end
        check("hold_no_enable", en, 0);
        check("hold_busy", busy, 1);
        check("hold_err", err, 0);
        finish_after(0);
`endif
        check("re_init_done_set", init_done, 1);

        // lcd_finish in IDLE is ignored; reset cleared the pending request
        lcd_finish = 1'b1;
        tick();
        lcd_finish = 1'b0;
        check("idle_finish_busy", busy, 0);
        wait_enable(n);
        check("post_rst_ref_delay", n, 19);
        check("post_rst_ref_ack", upd_ack, 0);
        check("post_rst_ref_mode", mode, 0);
`ifdef LCD_SEQ_TIMEOUT_EN
        check("err_sticky", err, 1);
`else
        check("err_tied", err, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
